// File: rtl/simon_pkg.sv
// Shared SIMON 32/64 constants, state encoding and the z0 sequence helper.
package simon_pkg;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned BLOCK_W = 32;
    localparam int unsigned KEY_W   = 64;

    localparam logic [WORD_W-1:0] C_CONST = 16'hFFFC;

    function automatic logic [61:0] reverse62(input logic [61:0] v);
        logic [61:0] r;
        r = '0;
        for (int unsigned i = 0; i < 62; i++) begin
            r[6'(i)] = v[6'(61 - i)];
        end
        return r;
    endfunction

    // Sequence written in reading order, stored so that Z0[i] is the i-th element.
    localparam logic [61:0] Z0 =
        reverse62(62'b11111010001001010110000111001101111101000100101011000011100110);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

endpackage

// File: rtl/simon32_keyexp.sv
// Combinational SIMON 32/64 key-schedule step: next key word from the window.
module simon32_keyexp
    import simon_pkg::*;
(
    input  logic [WORD_W-1:0] kw0_i,
    input  logic [WORD_W-1:0] kw1_i,
    input  logic [WORD_W-1:0] kw3_i,
    input  logic              z_i,
    output logic [WORD_W-1:0] knew_o
);

    logic [WORD_W-1:0] tmp;

    always_comb begin
        tmp    = {kw3_i[2:0], kw3_i[15:3]} ^ kw1_i;
        knew_o = C_CONST ^ {15'b0, z_i} ^ kw0_i ^ tmp ^ {tmp[0], tmp[15:1]};
    end

endmodule

// File: rtl/simon32_64_core.sv
// Iterative SIMON 32/64 encryptor: one round per clock, key expanded on the fly.
module simon32_64_core
    import simon_pkg::*;
#(
    parameter int unsigned ROUNDS = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [BLOCK_W-1:0] data_in,
    input  logic [KEY_W-1:0]   key_in,
    output logic [BLOCK_W-1:0] ciphertext,
    output logic               busy,
    output logic               valid
);

    state_e             state_q, state_d;
    logic [4:0]         rnd_q, rnd_d;
    logic [WORD_W-1:0]  x_q, x_d, y_q, y_d;
    logic [WORD_W-1:0]  kw0_q, kw0_d, kw1_q, kw1_d, kw2_q, kw2_d, kw3_q, kw3_d;
    logic [BLOCK_W-1:0] ct_q, ct_d;
    logic               valid_q, valid_d;

    logic [WORD_W-1:0]  f_x;
    logic [WORD_W-1:0]  x_next;
    logic [WORD_W-1:0]  knew;
    logic               z_bit;
    logic               last_round;

    simon32_keyexp u_keyexp (
        .kw0_i  (kw0_q),
        .kw1_i  (kw1_q),
        .kw3_i  (kw3_q),
        .z_i    (z_bit),
        .knew_o (knew)
    );

    always_comb begin
        z_bit      = Z0[{1'b0, rnd_q}];
        f_x        = ({x_q[14:0], x_q[15]} & {x_q[7:0], x_q[15:8]}) ^ {x_q[13:0], x_q[15:14]};
        x_next     = y_q ^ f_x ^ kw0_q;
        last_round = (rnd_q == 5'(ROUNDS - 1));
    end

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        x_d     = x_q;
        y_d     = y_q;
        kw0_d   = kw0_q;
        kw1_d   = kw1_q;
        kw2_d   = kw2_q;
        kw3_d   = kw3_q;
        ct_d    = ct_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    x_d     = data_in[31:16];
                    y_d     = data_in[15:0];
                    kw0_d   = key_in[15:0];
                    kw1_d   = key_in[31:16];
                    kw2_d   = key_in[47:32];
                    kw3_d   = key_in[63:48];
                    rnd_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d   = x_next;
                y_d   = x_q;
                kw0_d = kw1_q;
                kw1_d = kw2_q;
                kw2_d = kw3_q;
                kw3_d = knew;
                rnd_d = rnd_q + 5'd1;
                if (last_round) begin
                    ct_d    = {x_next, x_q};
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            kw0_q   <= '0;
            kw1_q   <= '0;
            kw2_q   <= '0;
            kw3_q   <= '0;
            ct_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            x_q     <= x_d;
            y_q     <= y_d;
            kw0_q   <= kw0_d;
            kw1_q   <= kw1_d;
            kw2_q   <= kw2_d;
            kw3_q   <= kw3_d;
            ct_q    <= ct_d;
            valid_q <= valid_d;
        end
    end

    assign ciphertext = ct_q;
    assign valid      = valid_q;
    assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_simon32_64_core.sv
// Self-checking bench for simon32_64_core: vector table, corner sequences, random scoreboard.
module tb_simon32_64_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [31:0] data_in;
    logic [63:0] key_in;
    logic [31:0] ciphertext;
    logic        busy;
    logic        valid;

    localparam logic [63:0] STD_KEY = 64'h1918_1110_0908_0100;
    localparam logic [31:0] STD_PT  = 32'h6565_6877;
    localparam logic [31:0] STD_CT  = 32'hC69B_E9BB;

    simon32_64_core #(.ROUNDS(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .data_in    (data_in),
        .key_in     (key_in),
        .ciphertext (ciphertext),
        .busy       (busy),
        .valid      (valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    logic [31:0] exp_q[$];
    int          last_valid = -1;
    logic        prev_valid = 1'b0;
    int          valid_cnt  = 0;

    typedef struct {
        logic [63:0] key;
        logic [31:0] pt;
        logic [31:0] ct;
    } vec_t;

    // Reference SIMON 32/64: full key schedule expanded into an array first.
    function automatic logic [31:0] simon_ref(input logic [63:0] key, input logic [31:0] pt);
        logic [15:0] k[0:31];
        logic [61:0] z;
        logic [15:0] x, y, t;
        z = 62'b11111010001001010110000111001101111101000100101011000011100110;
        k[0] = key[15:0];
        k[1] = key[31:16];
        k[2] = key[47:32];
        k[3] = key[63:48];
        for (int i = 4; i < 32; i++) begin
            t    = ((k[i-1] >> 3) | (k[i-1] << 13)) ^ k[i-3];
            t    = t ^ ((t >> 1) | (t << 15));
            k[i] = ~k[i-4] ^ t ^ {15'b0, z[61-(i-4)]} ^ 16'd3;
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            t = x;
            x = y ^ (((x << 1) | (x >> 15)) & ((x << 8) | (x >> 8))) ^ ((x << 2) | (x >> 14)) ^ k[i];
            y = t;
        end
        return {x, y};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            valid_cnt++;
            check32("valid single-cycle", {31'b0, prev_valid}, 32'd0);
            if (last_valid >= 0)
                check32("valid spacing>=33", {31'b0, (cyc - last_valid) >= 33}, 32'd1);
            last_valid = cyc;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected valid: got ct=%h want no valid", ciphertext);
            end else begin
                check32("scoreboard ct", ciphertext, exp_q.pop_front());
            end
        end
        prev_valid = valid;
    end

    task automatic pulse_load(input logic [63:0] k, input logic [31:0] p,
                              input logic [31:0] expct, output int at);
        @(posedge clk);
        #1;
        key_in  = k;
        data_in = p;
        load    = 1'b1;
        @(posedge clk);
        #1;
        at   = cyc;
        load = 1'b0;
        exp_q.push_back(expct);
    endtask

    task automatic wait_valid(input string name, output int at);
        at = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            total++;
            bad++;
            $display("FAIL %s: got no valid within 40 cycles want valid", name);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[6];
        int          at_load, at_v, bcnt, vbase;
        logic [63:0] rk;
        logic [31:0] rp, ct_a;

        reset   = 1'b1;
        load    = 1'b0;
        data_in = '0;
        key_in  = '0;

        tbl[0] = '{STD_KEY, STD_PT, STD_CT};
        tbl[1] = '{64'h0, 32'h0, 32'h0};
        tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        tbl[3] = '{64'h0123_4567_89AB_CDEF, 32'hDEAD_BEEF, 32'h0};
        tbl[4] = '{64'h8000_0000_0000_0001, 32'h0001_8000, 32'h0};
        tbl[5] = '{64'hA5A5_5A5A_3C3C_C3C3, 32'h1234_5678, 32'h0};
        for (int i = 1; i < 6; i++) tbl[i].ct = simon_ref(tbl[i].key, tbl[i].pt);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check32("reset ciphertext", ciphertext, 32'h0);
        check32("reset busy", {31'b0, busy}, 32'd0);
        check32("reset valid", {31'b0, valid}, 32'd0);

        // Standard vector: latency and busy duration.
        pulse_load(STD_KEY, STD_PT, STD_CT, at_load);
        bcnt = 0;
        at_v = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (busy === 1'b1) bcnt++;
            if (valid === 1'b1) begin
                at_v = cyc;
                break;
            end
        end
        check32("std latency", at_v - at_load, 32'd32);
        check32("std ct", ciphertext, STD_CT);
        check32("std busy cycles", bcnt, 32'd32);

        for (int i = 0; i < 6; i++) begin
            pulse_load(tbl[i].key, tbl[i].pt, tbl[i].ct, at_load);
            wait_valid("table valid", at_v);
            check32("table ct", ciphertext, tbl[i].ct);
        end

        // Load strobes on every RUN cycle must be ignored.
        pulse_load(STD_KEY, STD_PT, STD_CT, at_load);
        vbase = valid_cnt;
        for (int n = 1; n <= 31; n++) begin
            key_in  = {$urandom, $urandom};
            data_in = $urandom;
            load    = 1'b1;
            @(posedge clk);
            #1;
        end
        load = 1'b0;
        wait_valid("ignore-load valid", at_v);
        check32("ignore-load ct", ciphertext, STD_CT);
        check32("ignore-load latency", at_v - at_load, 32'd32);
        repeat (40) @(negedge clk);
        check32("ignore-load valid count", valid_cnt - vbase, 32'd1);

        // Reset in the middle of a run.
        pulse_load(32'h0 | STD_KEY, STD_PT, STD_CT, at_load);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check32("abort busy", {31'b0, busy}, 32'd0);
        check32("abort valid", {31'b0, valid}, 32'd0);
        check32("abort ciphertext", ciphertext, 32'h0);
        vbase = valid_cnt;
        repeat (40) @(negedge clk);
        check32("abort no valid", valid_cnt - vbase, 32'd0);
        pulse_load(STD_KEY, STD_PT, STD_CT, at_load);
        wait_valid("post-abort valid", at_v);
        check32("post-abort ct", ciphertext, STD_CT);

        // Back-to-back: second load lands in the valid cycle.
        ct_a = tbl[3].ct;
        pulse_load(tbl[3].key, tbl[3].pt, ct_a, at_load);
        wait_valid("b2b first valid", at_v);
        key_in  = tbl[5].key;
        data_in = tbl[5].pt;
        load    = 1'b1;
        @(posedge clk);
        #1;
        load    = 1'b0;
        at_load = cyc;
        exp_q.push_back(tbl[5].ct);
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            check32("b2b ct held", ciphertext, ct_a);
        end
        wait_valid("b2b second valid", at_v);
        check32("b2b latency", at_v - at_load, 32'd32);
        check32("b2b second ct", ciphertext, tbl[5].ct);

        // Reset and load together: reset wins.
        @(posedge clk);
        #1;
        reset   = 1'b1;
        load    = 1'b1;
        key_in  = STD_KEY;
        data_in = STD_PT;
        @(posedge clk);
        #1;
        reset = 1'b0;
        load  = 1'b0;
        @(negedge clk);
        check32("rst+load busy", {31'b0, busy}, 32'd0);
        check32("rst+load ciphertext", ciphertext, 32'h0);
        vbase = valid_cnt;
        repeat (40) @(negedge clk);
        check32("rst+load no valid", valid_cnt - vbase, 32'd0);

        for (int i = 0; i < 200; i++) begin
            rk = {$urandom, $urandom};
            rp = $urandom;
            pulse_load(rk, rp, simon_ref(rk, rp), at_load);
            wait_valid("random valid", at_v);
        end

        repeat (5) @(negedge clk);
        check32("scoreboard drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
